// File: rtl/npu_pack_pkg.sv
// npu_pack_pkg: shared definitions for the lane packer.
//   pack_state_e : packer FSM states (FILL, FLUSH_PEND)
//   lane_cnt_w() : width needed to hold a lane count 0..lanes
package npu_pack_pkg;

  typedef enum logic {
    FILL       = 1'b0,
    FLUSH_PEND = 1'b1
  } pack_state_e;

  function automatic int lane_cnt_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/elem_narrow.sv
// elem_narrow: combinational IN_W -> ELEM_W element narrowing.
// Build option: PACK_SATURATE_EN -- when defined, in_data is treated as
// signed and clamped to the ELEM_W signed range; otherwise the low ELEM_W
// bits are taken (truncation).
// Ports:
//   in_data  [IN_W-1:0]   : wide input element
//   out_elem [ELEM_W-1:0] : narrowed lane value
module elem_narrow #(
  parameter int IN_W   = 24,
  parameter int ELEM_W = 8
) (
  input  logic [IN_W-1:0]   in_data,
  output logic [ELEM_W-1:0] out_elem
);

`ifdef PACK_SATURATE_EN
  // Signed limits sign-extended to IN_W so the compare is a plain signed one.
  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-ELEM_W+1){1'b0}}, {(ELEM_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-ELEM_W+1){1'b1}}, {(ELEM_W-1){1'b0}}};

  always_comb begin
    if ($signed(in_data) > MAX_V)
      out_elem = {1'b0, {(ELEM_W-1){1'b1}}};
    else if ($signed(in_data) < MIN_V)
      out_elem = {1'b1, {(ELEM_W-1){1'b0}}};
    else
      out_elem = in_data[ELEM_W-1:0];
  end
`else
  assign out_elem = in_data[ELEM_W-1:0];

  // High bits are intentionally discarded in the truncating build.
  if (IN_W > ELEM_W) begin : g_drop
    logic unused_high;
    assign unused_high = ^in_data[IN_W-1:ELEM_W];
  end
`endif

endmodule

// File: rtl/lane_packer.sv
// lane_packer: packs a stream of narrowed elements into LANES-wide words.
// Build option: PACK_SATURATE_EN (saturating narrowing in elem_narrow).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous discard of all buffered data
//   in_valid/in_ready/in_data     : element stream (IN_W bits)
//   flush               : one-cycle request to emit a partial word
//   out_valid/out_ready/out_data  : packed word stream (ELEM_W*LANES bits)
//   out_lanes           : number of valid lanes in out_data
//   busy                : data buffered or a word held
module lane_packer
  import npu_pack_pkg::*;
#(
  parameter int IN_W   = 24,
  parameter int ELEM_W = 8,
  parameter int LANES  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_W-1:0]               in_data,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ELEM_W*LANES-1:0]       out_data,
  output logic [lane_cnt_w(LANES)-1:0]  out_lanes,
  output logic                          busy
);

  localparam int OUT_W = ELEM_W * LANES;
  localparam int LW    = lane_cnt_w(LANES);
  localparam int CW    = $clog2(LANES);

  pack_state_e      state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [OUT_W-1:0] lane_reg, lane_next;
  logic             out_valid_reg, out_valid_next;
  logic [OUT_W-1:0] out_data_reg, out_data_next;
  logic [LW-1:0]    out_lanes_reg, out_lanes_next;
  // Goes high on the first edge after reset so in_ready stays low in reset.
  logic             rdy_reg;

  logic [ELEM_W-1:0] elem;
  logic [OUT_W-1:0]  lane_wa;   // lane register including this cycle's accept
  logic              accept;
  logic              last_lane;
  logic              out_free;
  logic [LW-1:0]     cnt_acc;   // lane count after this cycle's accept

  elem_narrow #(
    .IN_W   (IN_W),
    .ELEM_W (ELEM_W)
  ) u_narrow (
    .in_data  (in_data),
    .out_elem (elem)
  );

  assign last_lane = (cnt_reg == CW'(LANES - 1));
  assign out_free  = !out_valid_reg || out_ready;
  assign in_ready  = rdy_reg && (state_reg == FILL) && (!last_lane || out_free);
  assign accept    = in_valid && in_ready;
  assign cnt_acc   = LW'(cnt_reg) + LW'(accept);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_wa[gi*ELEM_W +: ELEM_W] =
      (accept && cnt_reg == CW'(gi)) ? elem : lane_reg[gi*ELEM_W +: ELEM_W];
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    lane_next      = lane_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_lanes_next = out_lanes_reg;

    if (clear) begin
      state_next     = FILL;
      cnt_next       = '0;
      lane_next      = '0;
      out_valid_next = 1'b0;
      out_data_next  = '0;
      out_lanes_next = '0;
    end else begin
      case (state_reg)
        FILL: begin
          if (out_valid_reg && out_ready)
            out_valid_next = 1'b0;
          if (accept && last_lane) begin
            // Completing accept wins over a same-cycle flush: one full word.
            out_valid_next = 1'b1;
            out_data_next  = lane_wa;
            out_lanes_next = LW'(LANES);
            cnt_next       = '0;
            lane_next      = '0;
          end else if (flush && cnt_acc != '0) begin
            if (out_free) begin
              out_valid_next = 1'b1;
              out_data_next  = lane_wa;
              out_lanes_next = cnt_acc;
              cnt_next       = '0;
              lane_next      = '0;
            end else begin
              // Partial word parks in the lane register; cnt keeps its
              // lane count until the output register frees.
              lane_next  = lane_wa;
              cnt_next   = CW'(cnt_acc);
              state_next = FLUSH_PEND;
            end
          end else begin
            lane_next = lane_wa;
            if (accept)
              cnt_next = cnt_reg + 1'b1;
          end
        end
        FLUSH_PEND: begin
          // out_valid is always high here, so out_ready means it drains now.
          if (out_ready) begin
            out_valid_next = 1'b1;
            out_data_next  = lane_reg;
            out_lanes_next = LW'(cnt_reg);
            cnt_next       = '0;
            lane_next      = '0;
            state_next     = FILL;
          end
        end
        default: state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= FILL;
      cnt_reg       <= '0;
      lane_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_lanes_reg <= '0;
      rdy_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      lane_reg      <= lane_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_lanes_reg <= out_lanes_next;
      rdy_reg       <= 1'b1;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_lanes = out_lanes_reg;
  assign busy      = (cnt_reg != '0) || out_valid_reg || (state_reg == FLUSH_PEND);

endmodule

// File: tb/tb_lane_packer.sv
// tb_lane_packer: scoreboard bench for lane_packer at default parameters.
module tb_lane_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_lanes;
  logic        busy;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  l;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lane_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lanes (out_lanes),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Output monitor: every beat is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_beat", {32'h0, out_data}, 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("beat_data", {32'h0, out_data}, {32'h0, e.d});
        check_val("beat_lanes", {61'h0, out_lanes}, {61'h0, e.l});
      end
    end
  end

  // Offer one element (optionally with flush) until accepted; returns at posedge+1.
  task automatic send(input logic [23:0] d, input logic fl);
    int t = 0;
    in_data  = d;
    in_valid = 1'b1;
    flush    = fl;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check_val("send_timeout", 64'(in_ready), 64'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #22;
    check_val("rst_in_ready", 64'(in_ready), 64'h0);
    check_val("rst_busy", 64'(busy), 64'h0);
    check_val("rst_out_valid", 64'(out_valid), 64'h0);
    check_val("rst_out_data", 64'(out_data), 64'h0);
    check_val("rst_out_lanes", 64'(out_lanes), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_ready_still_low", 64'(in_ready), 64'h0);
    @(posedge clk);
    #1;
    check_val("ready_after_release", 64'(in_ready), 64'h1);

    // Four back-to-back elements -> one full word, one cycle after last accept
    exp_q.push_back('{32'h04030201, 3'd4});
    send(24'h01, 1'b0);
    send(24'h02, 1'b0);
    send(24'h03, 1'b0);
    check_val("no_early_valid", 64'(out_valid), 64'h0);
    send(24'h04, 1'b0);
    check_val("valid_after_4th", 64'(out_valid), 64'h1);
    idle(2);

    // Backpressure: word held, 3 more accepted, 8th refused until release
    out_ready = 1'b0;
    exp_q.push_back('{32'h04030201, 3'd4});
    exp_q.push_back('{32'h08070605, 3'd4});
    for (int i = 1; i <= 7; i++) send(24'(i), 1'b0);
    in_data  = 24'h08;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("stall_in_ready", 64'(in_ready), 64'h0);
      check_val("stall_hold_data", 64'(out_data), 64'h04030201);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(24'h08, 1'b0);
    idle(3);

    // Partial flush, then a no-op flush with cnt==0
    exp_q.push_back('{32'h0000BBAA, 3'd2});
    send(24'hAA, 1'b0);
    send(24'hBB, 1'b0);
    pulse_flush();
    idle(2);
    pulse_flush();
    idle(3);
    check_val("noop_flush_busy", 64'(busy), 64'h0);

    // Flush in the same cycle as the completing accept -> single full word
    exp_q.push_back('{32'h14131211, 3'd4});
    send(24'h11, 1'b0);
    send(24'h12, 1'b0);
    send(24'h13, 1'b0);
    send(24'h14, 1'b1);
    idle(3);
    check_val("flush_full_busy", 64'(busy), 64'h0);

    // Flush while a word is held -> FLUSH_PEND, then two beats in order
    out_ready = 1'b0;
    exp_q.push_back('{32'h24232221, 3'd4});
    exp_q.push_back('{32'h00003231, 3'd2});
    send(24'h21, 1'b0);
    send(24'h22, 1'b0);
    send(24'h23, 1'b0);
    send(24'h24, 1'b0);
    send(24'h31, 1'b0);
    send(24'h32, 1'b0);
    pulse_flush();
    in_data  = 24'h99;
    in_valid = 1'b1;
    @(negedge clk);
    check_val("pend_in_ready", 64'(in_ready), 64'h0);
    check_val("pend_busy", 64'(busy), 64'h1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("pend_back_to_fill", 64'(in_ready), 64'h1);
    idle(3);
    check_val("pend_done_busy", 64'(busy), 64'h0);

    // Narrowing: saturate or truncate
`ifdef PACK_SATURATE_EN
    exp_q.push_back('{32'h0005807F, 3'd3});
`else
    exp_q.push_back('{32'h00050000, 3'd3});
`endif
    send(24'h000200, 1'b0);
    send(24'hFFFE00, 1'b0);
    send(24'h000005, 1'b0);
    pulse_flush();
    idle(3);

    // clear with a held word and 3 lanes filled
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(24'h41 + 24'(i), 1'b0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check_val("clear_out_valid", 64'(out_valid), 64'h0);
    check_val("clear_busy", 64'(busy), 64'h0);
    out_ready = 1'b1;
    exp_q.push_back('{32'h54535251, 3'd4});
    for (int i = 0; i < 4; i++) send(24'h51 + 24'(i), 1'b0);
    idle(3);

    // Reset pulse mid-word discards the partial data
    send(24'h61, 1'b0);
    send(24'h62, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", 64'(out_valid), 64'h0);
    check_val("midrst_busy", 64'(busy), 64'h0);
    check_val("midrst_in_ready", 64'(in_ready), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back('{32'h74737271, 3'd4});
    for (int i = 0; i < 4; i++) send(24'h71 + 24'(i), 1'b0);

    // Drain scoreboard
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
    idle(2);
    check_val("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lane_packer.md
LANE_PACKER -- requirements
Module: lane_packer

Interface
REQ-001 Parameter IN_W, default 24: width of each input element before narrowing.
REQ-002 Parameter ELEM_W, default 8: width of one packed lane.
REQ-003 Parameter LANES, default 4, range 2..16: lanes per output word; OUT_W = ELEM_W*LANES.
REQ-004 Port clk, input, 1: the single clock; all state on rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port clear, input, 1: synchronous discard of all buffered data.
REQ-007 Ports in_valid (input, 1), in_ready (output, 1), in_data (input, IN_W): element stream.
REQ-008 Port flush, input, 1: single-cycle request to emit a partial word.
REQ-009 Ports out_valid (output, 1), out_ready (input, 1), out_data (output, OUT_W): packed word stream.
REQ-010 Port out_lanes, output, $clog2(LANES+1): number of valid lanes in out_data.
REQ-011 Port busy, output, 1: high when any element is buffered or a word is held.

Function
REQ-012 An element is accepted in any cycle where in_valid && in_ready; a word leaves in any cycle where out_valid && out_ready.
REQ-013 The accepted element, after narrowing (REQ-030/031), goes into lane cnt; lane 0 = out_data[ELEM_W-1:0], ascending.
REQ-014 cnt counts 0..LANES-1, increments per accepted element, and wraps to 0 when the word completes.
REQ-015 When the LANES-th element is accepted, the full word and out_lanes = LANES load the output register on the next edge; out_valid rises one cycle after the last accept.
REQ-016 in_ready = (cnt != LANES-1 || !out_valid || out_ready) && state != FLUSH_PEND; no element is ever dropped.
REQ-017 out_data and out_lanes hold stable while out_valid && !out_ready.
REQ-018 FSM states: FILL (normal) and FLUSH_PEND (partial word waiting for the output register).
REQ-019 A flush in FILL with cnt>0 (counted after any same-cycle accept) emits the partial word, zero-padded, with out_lanes = cnt, and resets cnt to 0. If the output register is free or draining that cycle, the word loads on the next edge; otherwise the FSM goes to FLUSH_PEND.
REQ-020 FLUSH_PEND: loads the partial word when the output register frees, then returns to FILL; in_ready = 0 throughout.
REQ-021 A flush with cnt==0 and no same-cycle accept is a no-op; a flush in FLUSH_PEND is ignored.
REQ-022 Flush in the same cycle as the accept that completes a word: the full word is emitted once, with no extra empty word.
REQ-023 clear has priority over accept, flush and drain: next cycle cnt=0, state=FILL, out_valid=0, and the lane register is zeroed.
REQ-024 Unfilled lanes always read zero; the lane register is zeroed whenever a word moves to the output register.
REQ-025 busy = (cnt != 0) || out_valid || (state == FLUSH_PEND).

Reset
REQ-026 rst_n low asynchronously forces cnt=0, state=FILL, lane register=0, out_valid=0, out_data=0, out_lanes=0.
REQ-027 During reset, in_ready=0 and busy=0; in_ready goes high on the first edge after deassertion.
REQ-028 A reset in the middle of a word discards the partial data; no output is produced.
REQ-029 All sequential logic is reset only by rst_n and clear; no other initialisation.

Configuration
REQ-030 With PACK_SATURATE_EN defined: in_data is treated as signed and clamped to [-2^(ELEM_W-1), 2^(ELEM_W-1)-1] before packing.
REQ-031 Without PACK_SATURATE_EN: the element is in_data[ELEM_W-1:0] (truncation). Interface and timing are identical in both builds.

Structure
REQ-032 Package npu_pack_pkg holds the state enum (FILL, FLUSH_PEND) and a lane-count-width function.
REQ-033 Sub-module elem_narrow (IN_W to ELEM_W, saturate or truncate) is the only child, combinational.

Verification
REQ-034 Defaults, out_ready=1, elements 0x01,0x02,0x03,0x04 back-to-back -> one beat out_data=0x04030201, out_lanes=4, one cycle after the 4th accept.
REQ-035 out_ready=0, 8 elements offered -> 0x04030201 held, 3 more accepted, in_ready=0 at the 8th; after out_ready=1 -> 0x08070605 follows.
REQ-036 Elements 0xAA,0xBB then flush -> out_data=0x0000BBAA, out_lanes=2; a second flush with cnt=0 -> no beat.
REQ-037 Flush while a word is held and out_ready=0 -> FLUSH_PEND, in_ready=0; on release, two beats in order, then FILL.
REQ-038 PACK_SATURATE_EN: in_data 0x000200 -> lane 0x7F, 0xFFFE00 -> 0x80, 0x000005 -> 0x05; without the macro -> 0x00, 0x00, 0x05.
REQ-039 clear with 3 lanes filled and a word held, and rst_n pulsed mid-word -> out_valid=0, busy=0, and the next 4 elements give a clean word.
